pc_redirect_ctrl: RTL and testbench

Fetch-PC sequencer for the RV32I core. Holds the architectural fetch PC and selects each cycle between sequential PC+4, the branch/JAL target from the jump-target adder, and the JALR target from the ALU. On a taken control transfer it redirects fetch and sequences a multi-cycle flush of the younger pipeline stages. Sits between the jump-target adder / branch comparator and the instruction-fetch stage.

---
 rtl/pc_redirect_ctrl.sv | 125 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: sequential/branch/JAL/JALR select plus post-redirect flush.
// Optional: `define PC_REDIRECT_MISALIGN_TRAP_EN to trap misaligned targets to TRAP_VEC.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        ip_clk,
    input  logic        ip_rst,
    input  logic        ip_stall,
    input  logic        ip_is_branch,
    input  logic        ip_br_taken,
    input  logic        ip_is_jal,
    input  logic        ip_is_jalr,
    input  logic [31:0] ip_Add_J,
    input  logic [31:0] ip_jalr_tgt,
    output logic [31:0] op_PC,
    output logic [31:0] op_PC_plus4,
    output logic        op_redirect,
    output logic        op_flush,
    output logic        op_misalign
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        redirect_q, redirect_d;

    logic        req;
    logic        trap_hit;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic [31:0] tgt_aligned;

    assign req = (ip_is_branch & ip_br_taken) | ip_is_jal | ip_is_jalr;
    assign pc_plus4 = pc_q + 32'd4;

    // JALR wins over JAL/branch; both of the latter use the adder output
    always_comb begin
        tgt = ip_Add_J;
        if (ip_is_jalr) begin
            tgt = ip_jalr_tgt & ~32'h1;
        end
    end

    assign tgt_aligned = tgt & ~32'h3;

`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
    logic misalign_q;

    assign trap_hit = |tgt[1:0];

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == RUN) & req & trap_hit;
        end
    end

    assign op_misalign = misalign_q;
`else
    assign trap_hit    = 1'b0;
    assign op_misalign = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (req) begin
                    pc_d       = trap_hit ? TRAP_VEC : tgt_aligned;
                    redirect_d = 1'b1;
                    cnt_d      = CNT_INIT;
                    state_d    = FLUSH;
                end else if (!ip_stall) begin
                    pc_d = pc_plus4;
                end
            end
            FLUSH: begin
                // requests here come from killed instructions
                if (!ip_stall) begin
                    pc_d  = pc_plus4;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    assign op_PC       = pc_q;
    assign op_PC_plus4 = pc_plus4;
    assign op_redirect = redirect_q;
    assign op_flush    = (state_q == FLUSH);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: directed plan followed by random traffic.
module tb_pc_redirect_ctrl;

    localparam int          FC     = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        ip_rst = 1'b1;
    logic        ip_stall = 1'b0;
    logic        ip_is_branch = 1'b0;
    logic        ip_br_taken = 1'b0;
    logic        ip_is_jal = 1'b0;
    logic        ip_is_jalr = 1'b0;
    logic [31:0] ip_Add_J = '0;
    logic [31:0] ip_jalr_tgt = '0;
    logic [31:0] op_PC;
    logic [31:0] op_PC_plus4;
    logic        op_redirect;
    logic        op_flush;
    logic        op_misalign;

    always #5 clk = ~clk;

    pc_redirect_ctrl #(
        .RESET_PC    (RST_PC),
        .TRAP_VEC    (TRAP),
        .FLUSH_CYCLES(FC)
    ) dut (
        .ip_clk      (clk),
        .ip_rst      (ip_rst),
        .ip_stall    (ip_stall),
        .ip_is_branch(ip_is_branch),
        .ip_br_taken (ip_br_taken),
        .ip_is_jal   (ip_is_jal),
        .ip_is_jalr  (ip_is_jalr),
        .ip_Add_J    (ip_Add_J),
        .ip_jalr_tgt (ip_jalr_tgt),
        .op_PC       (op_PC),
        .op_PC_plus4 (op_PC_plus4),
        .op_redirect (op_redirect),
        .op_flush    (op_flush),
        .op_misalign (op_misalign)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        red;
        logic        fl;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    logic [31:0] m_pc = '0;
    int          m_left = 0;

    // reference: PC and remaining flush cycles, updated from the rules
    task automatic step(input logic rst, input logic stall,
                        input logic br, input logic tk,
                        input logic jal, input logic jalr,
                        input logic [31:0] addj, input logic [31:0] jt);
        exp_t e;
        logic [31:0] t;
        @(negedge clk);
        ip_rst       = rst;
        ip_stall     = stall;
        ip_is_branch = br;
        ip_br_taken  = tk;
        ip_is_jal    = jal;
        ip_is_jalr   = jalr;
        ip_Add_J     = addj;
        ip_jalr_tgt  = jt;
        e.red = 1'b0;
        e.mis = 1'b0;
        if (rst) begin
            m_pc   = RST_PC;
            m_left = 0;
        end else if (m_left == 0 && ((br && tk) || jal || jalr)) begin
            t = jalr ? jt - (jt % 2) : addj;
            e.red  = 1'b1;
            m_left = FC;
            if (t % 4 != 0) begin
`ifdef PC_REDIRECT_MISALIGN_TRAP_EN
                m_pc  = TRAP;
                e.mis = 1'b1;
`else
                m_pc = t - (t % 4);
`endif
            end else begin
                m_pc = t;
            end
        end else if (!stall) begin
            m_pc = m_pc + 32'd4;
            if (m_left > 0) m_left--;
        end
        e.pc = m_pc;
        e.fl = (m_left > 0);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", op_PC, e.pc);
                chk("pc_plus4", op_PC_plus4, e.pc + 32'd4);
                chk("redirect", {31'd0, op_redirect}, {31'd0, e.red});
                chk("flush", {31'd0, op_flush}, {31'd0, e.fl});
                chk("misalign", {31'd0, op_misalign}, {31'd0, e.mis});
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        logic        rs;
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 0, 0, 0, 1, 0, 32'h80, 32'h0);
        idle(4);
        step(0, 0, 1, 1, 0, 0, 32'h40, 32'h0);
        idle(3);
        step(0, 0, 0, 0, 1, 1, 32'h80, 32'h201);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 32'h100, 32'h0);
        step(0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 32'h600, 32'h0);
        step(0, 0, 0, 0, 1, 0, 32'h500, 32'h0);
        idle(2);
        step(0, 0, 0, 0, 1, 0, 32'h300, 32'h0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle(1);
        step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFF4, 32'h0);
        idle(3);
        step(0, 0, 0, 0, 1, 0, 32'h0000_0042, 32'h0);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0000_0123);
        idle(2);
        step(0, 0, 1, 0, 0, 0, 32'h800, 32'h0);
        idle(1);
        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
            if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0 | (a & 32'hF);
            rs = ($urandom_range(0, 49) == 0);
            step(rs,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 a, $urandom);
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #5;
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
